// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared state encoding and sizing constants for the MIPS data-memory responder
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int BYTE_LANES = 4;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with byte-lane synchronous write and asynchronous read
module data_mem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [BYTE_LANES-1:0] be,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data-memory responder with ACK/ERR and pipeline STALL
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [31:0]           ADDR,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [BYTE_LANES-1:0] BE,
  output logic [DATA_W-1:0]     RDATA,
  output logic                  ACK,
  output logic                  ERR,
  output logic                  STALL
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                  state;
  logic [CNT_W-1:0]        cnt;

  logic                    lat_we;
  logic [31:0]             lat_addr;
  logic [DATA_W-1:0]       lat_wdata;
  logic [BYTE_LANES-1:0]   lat_be;

  logic                    accept;
  logic                    enter_resp;
  logic                    acc_we;
  logic [31:0]             acc_addr;
  logic [DATA_W-1:0]       acc_wdata;
  logic [BYTE_LANES-1:0]   acc_be;
  logic                    acc_err;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_rdata;

  assign accept = (state == IDLE) && REQ;

  // With zero latency the access completes on its acceptance edge, so the
  // live request must steer the array before it has been latched.
  assign acc_we    = (state == IDLE) ? WE    : lat_we;
  assign acc_addr  = (state == IDLE) ? ADDR  : lat_addr;
  assign acc_wdata = (state == IDLE) ? WDATA : lat_wdata;
  assign acc_be    = (state == IDLE) ? BE    : lat_be;

  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W+2] != '0);

  assign enter_resp = (accept && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt <= CNT_ONE));

  assign mem_we = enter_resp && acc_we && !acc_err;

  data_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (acc_addr[ADDR_W+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK) begin
    if (accept) begin
      lat_we    <= WE;
      lat_addr  <= ADDR;
      lat_wdata <= WDATA;
      lat_be    <= BE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      RDATA <= '0;
      ERR   <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            cnt   <= LAT_CNT;
            state <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt <= CNT_ONE) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Load data and the error flag are captured on the edge into RESP;
      // stores and rejected accesses leave RDATA holding the last load.
      if (enter_resp) begin
        ERR <= acc_err;
        if (!acc_we && !acc_err) begin
          RDATA <= mem_rdata;
        end
      end
    end
  end

  assign ACK   = (state == RESP);
  assign STALL = accept || (state == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at LATENCY 2 and 0
module tb_data_mem_responder;

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_cyc;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_s   [2];
  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [3:0]  be_s    [2];
  logic [31:0] rdata_s [2];
  logic        ack_s   [2];
  logic        err_s   [2];
  logic        stall_s [2];

  data_mem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(2)) dut_l2 (
    .CLK(clk), .RST(rst_s[0]), .REQ(req_s[0]), .WE(we_s[0]), .ADDR(addr_s[0]),
    .WDATA(wdata_s[0]), .BE(be_s[0]), .RDATA(rdata_s[0]), .ACK(ack_s[0]),
    .ERR(err_s[0]), .STALL(stall_s[0])
  );

  data_mem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(0)) dut_l0 (
    .CLK(clk), .RST(rst_s[1]), .REQ(req_s[1]), .WE(we_s[1]), .ADDR(addr_s[1]),
    .WDATA(wdata_s[1]), .BE(be_s[1]), .RDATA(rdata_s[1]), .ACK(ack_s[1]),
    .ERR(err_s[1]), .STALL(stall_s[1])
  );

  logic [31:0] mm          [2][1024];
  logic [31:0] model_rdata [2];
  int          acc_a       [2];
  int          acc_b       [2];
  int          next_acc    [2];
  req_t        sb [$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;

  function automatic int lat(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit addr_err(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
  endfunction

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", name, d, cyc, act, exp);
    end
  endtask

  task automatic monitor_dut(int d);
    int   idx;
    int   c;
    int   l;
    int   w;
    bit   exp_ack;
    bit   exp_err;
    bit   in_wait;
    bit   in_resp;
    bit   exp_stall;
    req_t e;
    c   = cyc;
    l   = lat(d);
    idx = -1;
    foreach (sb[i]) if (idx < 0 && sb[i].d == d) idx = i;
    exp_ack = (idx >= 0) && (sb[idx].ack_cyc == c);
    exp_err = 1'b0;
    chk("ack", d, ack_s[d], exp_ack);
    if (exp_ack) begin
      e = sb[idx];
      sb.delete(idx);
      exp_err = addr_err(e.addr);
      w = int'(e.addr[11:2]);
      if (ack_s[d] && !exp_err) begin
        if (e.we) begin
          for (int b = 0; b < 4; b++) if (e.be[b]) mm[d][w][8*b +: 8] = e.wdata[8*b +: 8];
        end else begin
          model_rdata[d] = mm[d][w];
        end
      end
    end
    chk("err", d, err_s[d], exp_err);
    chk("rdata", d, rdata_s[d], model_rdata[d]);
    in_wait = (c >= acc_a[d] && c < acc_a[d] + l) || (c >= acc_b[d] && c < acc_b[d] + l);
    in_resp = (c == acc_a[d] + l) || (c == acc_b[d] + l);
    exp_stall = in_wait || (!in_resp && req_s[d]);
    chk("stall", d, stall_s[d], exp_stall);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor_dut(0);
      monitor_dut(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: complete with an idle gap; 1: return in the ACK cycle with REQ
  // still high; 2: return in the first cycle after acceptance.
  task automatic issue(int d, logic we, logic [31:0] addr, logic [31:0] wdata,
                       logic [3:0] be, int mode);
    int   acc;
    req_t e;
    acc = (cyc + 1 > next_acc[d]) ? cyc + 1 : next_acc[d];
    we_s[d] = we; addr_s[d] = addr; wdata_s[d] = wdata; be_s[d] = be; req_s[d] = 1'b1;
    e.d = d; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be; e.ack_cyc = acc + lat(d);
    sb.push_back(e);
    acc_b[d]    = acc_a[d];
    acc_a[d]    = acc;
    next_acc[d] = acc + lat(d) + 2;
    while (cyc < acc) step();
    if (mode != 1) req_s[d] = 1'b0;
    if (mode == 2) return;
    while (cyc < acc + lat(d)) step();
    if (mode == 0) step();
  endtask

  task automatic reset_dut(int d, int n);
    rst_s[d] = 1'b1;
    req_s[d] = 1'b0;
    step();
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
    model_rdata[d] = 32'h0;
    acc_a[d] = -100; acc_b[d] = -100; next_acc[d] = 0;
    repeat (n - 1) step();
    rst_s[d] = 1'b0;
  endtask

  task automatic init_words(int d);
    for (int w = 0; w < 16; w++) issue(d, 1'b1, 32'(w) << 2, $urandom, 4'hF, 0);
  endtask

  task automatic rand_ops(int d, int n);
    logic [31:0] a;
    int          r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = a | (32'($urandom_range(1, 255)) << 12);
      issue(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    req_s[d] = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; req_s[d] = 1'b0; we_s[d] = 1'b0;
      addr_s[d] = 32'h0; wdata_s[d] = 32'h0; be_s[d] = 4'h0;
      model_rdata[d] = 32'h0;
      acc_a[d] = -100; acc_b[d] = -100; next_acc[d] = 0;
    end
    step();
    mon_en = 1'b1;
    step();
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    repeat (2) step();

    fork
      init_words(0);
      init_words(1);
    join

    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
    issue(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    issue(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    issue(0, 1'b0, 32'h20, 32'h0, 4'hF, 0);
    issue(0, 1'b0, 32'h13, 32'h0, 4'hF, 0);
    issue(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 0);
    issue(0, 1'b0, 32'h0, 32'h0, 4'hF, 0);
    issue(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 0);
    issue(0, 1'b0, 32'h24, 32'h0, 4'h0, 0);

    issue(0, 1'b1, 32'h30, 32'h0F0F0F0F, 4'hF, 2);
    reset_dut(0, 2);
    step();
    issue(0, 1'b0, 32'h30, 32'h0, 4'hF, 0);

    issue(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0);
    issue(1, 1'b1, 32'h20, 32'h0BADC0DE, 4'hF, 0);
    issue(1, 1'b0, 32'h10, 32'h0, 4'hF, 1);
    issue(1, 1'b0, 32'h20, 32'h0, 4'hF, 0);

    fork
      rand_ops(0, 60);
      rand_ops(1, 60);
    join

    repeat (5) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_responses actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
